// File: rtl/cpu_types_pkg.sv
// Shared CPU control types used by the pipeline control logic.
package cpu_types_pkg;

   // Hazard controller operating state.
   typedef enum logic [1:0] {
      HazRun    = 2'd0,
      HazDrain  = 2'd1,
      HazHalted = 2'd2
   } haz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard controller signals as seen by the datapath.
interface hazard_ctrl_if #(
   parameter int unsigned NLATCH = 4,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 16
);
   logic              CLK;
   logic              RST;
   logic              ihit;
   logic              dhit;
   logic              dmemREN;
   logic              dmemWEN;
   logic              mispredict;
   logic              jumping;
   logic              halt;
   logic              ex_memread;
   logic [REG_W-1:0]  ex_rd;
   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic              pc_en;
   logic [NLATCH-1:0] en;
   logic [NLATCH-1:0] flush;
   logic              halted;
   logic [CNT_W-1:0]  stall_count;

   modport haz (
      input  CLK, RST, ihit, dhit, dmemREN, dmemWEN, mispredict, jumping, halt,
      input  ex_memread, ex_rd, id_rs, id_rt,
      output pc_en, en, flush, halted, stall_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: latch enables/flushes, PC enable, halt drain
// sequencing and a saturating stall-cycle counter.
module hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int unsigned NSTAGES    = 5,
   parameter int unsigned MEM_STAGE  = 3,
   parameter int unsigned BR_STAGE   = 2,
   parameter int unsigned HALT_STAGE = 1,
   parameter int unsigned REG_W      = 5,
   parameter int unsigned CNT_W      = 16,
   localparam int unsigned NLATCH    = NSTAGES - 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              dmemREN,
   input  logic              dmemWEN,
   input  logic              mispredict,
   input  logic              jumping,
   input  logic              halt,
   input  logic              ex_memread,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   output logic              pc_en,
   output logic [NLATCH-1:0] en,
   output logic [NLATCH-1:0] flush,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_count
);

   if (!(BR_STAGE > 0 && BR_STAGE < MEM_STAGE && MEM_STAGE < NSTAGES)) begin : g_bad_stages
      $fatal(1, "hazard_ctrl: need 0 < BR_STAGE < MEM_STAGE < NSTAGES");
   end
   if (!(HALT_STAGE < NSTAGES)) begin : g_bad_halt
      $fatal(1, "hazard_ctrl: need HALT_STAGE < NSTAGES");
   end

   localparam int unsigned DRAIN_W = $clog2(NSTAGES + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(NSTAGES - 1 - HALT_STAGE);

   // Latches upstream of MEM freeze on a data stall; the latch after MEM gets a bubble
   // (the mask is empty when MEM is the last stage).
   localparam logic [NLATCH-1:0] MEM_HOLD   = NLATCH'((1 << MEM_STAGE) - 1);
   localparam logic [NLATCH-1:0] MEM_BUBBLE = NLATCH'(1 << MEM_STAGE);
   localparam logic [NLATCH-1:0] BR_SQUASH  = NLATCH'((1 << BR_STAGE) - 1);
   localparam logic [NLATCH-1:0] LU_BUBBLE  = NLATCH'(1 << (BR_STAGE - 1));

   haz_state_t         state_q, state_d;
   logic               redir_pend_q, redir_pend_d;
   logic               halt_pend_q, halt_pend_d;
   logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic memstall, redirect_now, redirect, loaduse;

   assign memstall     = (dmemREN | dmemWEN) & ~dhit;
   assign redirect_now = mispredict | jumping;
   assign redirect     = redirect_now | redir_pend_q;
   assign loaduse      = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

   // Combinational latch/PC controls from current state and hazard sources.
   always_comb begin
      pc_en = 1'b1;
      en    = '1;
      flush = '0;
      if (RST) begin
         pc_en = 1'b0;
         en    = '0;
         flush = '1;
      end else begin
         unique case (state_q)
            HazHalted: begin
               pc_en = 1'b0;
               en    = '0;
            end
            HazDrain: begin
               pc_en = 1'b0;
               if (memstall) begin
                  en    = ~MEM_HOLD;
                  flush = MEM_BUBBLE;
               end else begin
                  flush = NLATCH'(1);
               end
            end
            default: begin
               if (memstall) begin
                  pc_en = 1'b0;
                  en    = ~MEM_HOLD;
                  flush = MEM_BUBBLE;
               end else if (redirect) begin
                  flush = BR_SQUASH;
               end else if (loaduse) begin
                  pc_en = 1'b0;
                  en[0] = 1'b0;
                  flush = LU_BUBBLE;
               end else if (!ihit) begin
                  pc_en = 1'b0;
                  flush = NLATCH'(1);
               end
            end
         endcase
      end
   end

   // Next-state: FSM, pending flags, drain countdown and stall counter.
   always_comb begin
      state_d      = state_q;
      redir_pend_d = redir_pend_q;
      halt_pend_d  = halt_pend_q;
      drain_cnt_d  = drain_cnt_q;
      stall_cnt_d  = stall_cnt_q;

      if (state_q != HazHalted && !pc_en && stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         HazHalted: ;
         HazDrain: begin
            // The halt is already committed; any redirect here targets squashed work.
            redir_pend_d = 1'b0;
            halt_pend_d  = 1'b0;
            if (!memstall) begin
               drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
               if (drain_cnt_q <= DRAIN_W'(1)) begin
                  drain_cnt_d = '0;
                  state_d     = HazHalted;
               end
            end
         end
         default: begin
            if (memstall) begin
               if (redirect_now) redir_pend_d = 1'b1;
               if (halt)         halt_pend_d  = 1'b1;
            end else if (redirect) begin
               // A younger halt is wrong-path and is dropped with the redirect.
               redir_pend_d = 1'b0;
               halt_pend_d  = 1'b0;
            end else if (halt || halt_pend_q) begin
               halt_pend_d = 1'b0;
               drain_cnt_d = DRAIN_INIT;
               state_d     = (DRAIN_INIT == '0) ? HazHalted : HazDrain;
            end
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= HazRun;
         redir_pend_q <= 1'b0;
         halt_pend_q  <= 1'b0;
         drain_cnt_q  <= '0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         redir_pend_q <= redir_pend_d;
         halt_pend_q  <= halt_pend_d;
         drain_cnt_q  <= drain_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign halted      = (state_q == HazHalted) && !RST;
   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with default parameters.
module tb_hazard_ctrl;

   hazard_ctrl_if #(.NLATCH(4), .REG_W(5), .CNT_W(16)) hif ();

   int n_cmp = 0;
   int n_err = 0;

   hazard_ctrl dut (
      .CLK         (hif.CLK),
      .RST         (hif.RST),
      .ihit        (hif.ihit),
      .dhit        (hif.dhit),
      .dmemREN     (hif.dmemREN),
      .dmemWEN     (hif.dmemWEN),
      .mispredict  (hif.mispredict),
      .jumping     (hif.jumping),
      .halt        (hif.halt),
      .ex_memread  (hif.ex_memread),
      .ex_rd       (hif.ex_rd),
      .id_rs       (hif.id_rs),
      .id_rt       (hif.id_rt),
      .pc_en       (hif.pc_en),
      .en          (hif.en),
      .flush       (hif.flush),
      .halted      (hif.halted),
      .stall_count (hif.stall_count)
   );

   initial hif.CLK = 1'b0;
   always #5 hif.CLK = ~hif.CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change 1ns after it.
   task automatic step();
      @(posedge hif.CLK);
      #1;
   endtask

   task automatic outs(input string tag, input logic pc, input logic [3:0] e, input logic [3:0] f);
      #1;
      check({tag, ".pc_en"}, 32'(hif.pc_en), 32'(pc));
      check({tag, ".en"}, 32'(hif.en), 32'(e));
      check({tag, ".flush"}, 32'(hif.flush), 32'(f));
   endtask

   initial begin
      hif.RST = 1'b1;       hif.ihit = 1'b1;       hif.dhit = 1'b1;
      hif.dmemREN = 1'b0;   hif.dmemWEN = 1'b0;    hif.mispredict = 1'b0;
      hif.jumping = 1'b0;   hif.halt = 1'b0;       hif.ex_memread = 1'b0;
      hif.ex_rd = '0;       hif.id_rs = '0;        hif.id_rt = '0;

      // Reset held two cycles.
      step();
      step();
      outs("rst", 1'b0, 4'b0000, 4'b1111);
      check("rst.halted", 32'(hif.halted), 32'd0);

      hif.RST = 1'b0;
      outs("run", 1'b1, 4'b1111, 4'b0000);
      check("run.count", 32'(hif.stall_count), 32'd0);

      // Data stall for three cycles.
      hif.dmemREN = 1'b1; hif.dhit = 1'b0;
      outs("dstall0", 1'b0, 4'b1000, 4'b1000);
      step();
      outs("dstall1", 1'b0, 4'b1000, 4'b1000);
      step();
      step();
      hif.dhit = 1'b1;
      outs("dstall_done", 1'b1, 4'b1111, 4'b0000);
      check("dstall.count", 32'(hif.stall_count), 32'd3);
      step();
      hif.dmemREN = 1'b0;

      // Mispredict during a dmem stall is held until the stall clears.
      hif.dmemWEN = 1'b1; hif.dhit = 1'b0;
      step();
      hif.mispredict = 1'b1;
      outs("redir_in_stall", 1'b0, 4'b1000, 4'b1000);
      step();
      hif.mispredict = 1'b0;
      step();
      hif.dhit = 1'b1;
      outs("redir_pend", 1'b1, 4'b1111, 4'b0011);
      step();
      hif.dmemWEN = 1'b0;
      outs("redir_clear", 1'b1, 4'b1111, 4'b0000);
      check("redir.count", 32'(hif.stall_count), 32'd6);

      // Load-use on rt, then with ex_rd=0, then masked by a redirect.
      hif.ex_memread = 1'b1; hif.ex_rd = 5'd5; hif.id_rt = 5'd5;
      outs("loaduse", 1'b0, 4'b1110, 4'b0010);
      step();
      hif.ex_rd = 5'd0; hif.id_rt = 5'd0;
      outs("loaduse_r0", 1'b1, 4'b1111, 4'b0000);
      hif.ex_rd = 5'd9; hif.id_rs = 5'd9; hif.mispredict = 1'b1;
      outs("loaduse_vs_redir", 1'b1, 4'b1111, 4'b0011);
      hif.ex_memread = 1'b0; hif.ex_rd = '0; hif.id_rs = '0; hif.mispredict = 1'b0;
      step();
      check("loaduse.count", 32'(hif.stall_count), 32'd7);

      // Fetch miss with and without a jump.
      hif.ihit = 1'b0; hif.jumping = 1'b1;
      outs("imiss_jump", 1'b1, 4'b1111, 4'b0011);
      hif.jumping = 1'b0;
      outs("imiss", 1'b0, 4'b1111, 4'b0001);
      step();
      hif.ihit = 1'b1;

      // Halt coinciding with a redirect is dropped.
      hif.halt = 1'b1; hif.jumping = 1'b1;
      outs("halt_vs_redir", 1'b1, 4'b1111, 4'b0011);
      step();
      hif.halt = 1'b0; hif.jumping = 1'b0;
      outs("halt_dropped", 1'b1, 4'b1111, 4'b0000);
      check("halt_dropped.halted", 32'(hif.halted), 32'd0);

      // Halt drain: three non-stall DRAIN cycles, stretched by a 2-cycle dmem stall.
      hif.halt = 1'b1;
      outs("halt_req", 1'b1, 4'b1111, 4'b0000);
      step();
      hif.halt = 1'b0;
      outs("drain0", 1'b0, 4'b1111, 4'b0001);
      check("drain0.halted", 32'(hif.halted), 32'd0);
      step();
      hif.dmemREN = 1'b1; hif.dhit = 1'b0;
      outs("drain_stall", 1'b0, 4'b1000, 4'b1000);
      step();
      step();
      hif.dhit = 1'b1;
      outs("drain1", 1'b0, 4'b1111, 4'b0001);
      step();
      hif.dmemREN = 1'b0;
      outs("drain2", 1'b0, 4'b1111, 4'b0001);
      check("drain2.halted", 32'(hif.halted), 32'd0);
      step();
      outs("halted", 1'b0, 4'b0000, 4'b0000);
      check("halted.flag", 32'(hif.halted), 32'd1);
      check("halted.count", 32'(hif.stall_count), 32'd13);

      // HALTED ignores activity and freezes the counter.
      hif.ihit = 1'b0; hif.dmemREN = 1'b1; hif.dhit = 1'b0; hif.mispredict = 1'b1;
      step();
      step();
      outs("halted_hold", 1'b0, 4'b0000, 4'b0000);
      check("halted_hold.flag", 32'(hif.halted), 32'd1);
      check("halted_hold.count", 32'(hif.stall_count), 32'd13);
      hif.ihit = 1'b1; hif.dmemREN = 1'b0; hif.dhit = 1'b1; hif.mispredict = 1'b0;

      // Reset out of HALTED.
      hif.RST = 1'b1;
      outs("rst_halted", 1'b0, 4'b0000, 4'b1111);
      check("rst_halted.flag", 32'(hif.halted), 32'd0);
      step();
      hif.RST = 1'b0;
      outs("rerun", 1'b1, 4'b1111, 4'b0000);
      check("rerun.halted", 32'(hif.halted), 32'd0);
      check("rerun.count", 32'(hif.stall_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the N-stage MIPS core. It generates per-latch enable and flush controls plus the PC enable from these sources:
- cache hits (`ihit`, `dhit`)
- pending data-memory requests
- load-use dependencies
- branch/jump redirects
- halt

It adds a registered redirect-pending flag, a halt drain sequencer, and a saturating stall-cycle counter. It sits beside the pipeline latches in the datapath, one instance per core.

## Interface
Parameters:
- `NSTAGES`, 5: pipeline stages. Stage 0 = IF. `NLATCH = NSTAGES-1`. Latch i sits between stage i and i+1.
- `MEM_STAGE`, 3: stage that accesses dmem.
- `BR_STAGE`, 2: stage where branches/jumps resolve.
- `HALT_STAGE`, 1: stage that raises `halt`.
- `REG_W`, 5: register address width.
- `CNT_W`, 16: stall counter width.

Ports:
- `CLK` in 1: clock. One clock domain; reset is synchronous and active-high.
- `RST` in 1: synchronous, active-high reset.
- `ihit` in 1: instruction fetch complete.
- `dhit` in 1: data access complete.
- `dmemREN`, `dmemWEN` in 1 each: MEM-stage data request.
- `mispredict`, `jumping` in 1 each: redirect from `BR_STAGE`.
- `halt` in 1: halt decoded in `HALT_STAGE`.
- `ex_memread` in 1: instruction in EX is a load.
- `ex_rd` in `REG_W`: load destination register.
- `id_rs`, `id_rt` in `REG_W` each: ID source registers.
- `pc_en` out 1: PC update enable.
- `en` out `NLATCH`: latch enables.
- `flush` out `NLATCH`: bubble insert. When `flush[i]` is high, latch i loads a nop on the edge; flush overrides `en`.
- `halted` out 1: core stopped.
- `stall_count` out `CNT_W`: cycles with `pc_en=0` while in RUN or DRAIN.

## Operation
- FSM states: RUN, DRAIN, HALTED.
- Default outputs in RUN: `pc_en=1`, `en` all ones, `flush` all zeros.
- Derived conditions:
  - `memstall = (dmemREN|dmemWEN) & ~dhit`.
  - `redirect = mispredict | jumping | redir_pend`.
  - `loaduse = ex_memread & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt)`.
- Priority, highest first:
  1. RST
  2. HALTED
  3. memstall
  4. redirect
  5. loaduse
  6. `~ihit`
- memstall:
  - `pc_en=0`.
  - `en[i]=0` for i<`MEM_STAGE`.
  - `flush[MEM_STAGE]=1` (bubble into the stage after MEM).
  - Later latches stay enabled.
  - A `mispredict` or `jumping` seen during the stall sets `redir_pend`.
- redirect:
  - `pc_en=1` (target loaded).
  - `flush[i]=1` for all i<`BR_STAGE`.
  - Clears `redir_pend` on the edge.
- loaduse:
  - `pc_en=0`, `en[0]=0`.
  - `flush[BR_STAGE-1]=1` (bubble into EX).
- `~ihit`: `pc_en=0`, `flush[0]=1`.
- halt, in RUN with no memstall:
  - Go to DRAIN with `drain_cnt = NSTAGES-1-HALT_STAGE`.
  - If that value is 0, go directly to HALTED.
  - A halt during memstall is latched into `halt_pend` and acted on the first non-stall cycle.
- DRAIN:
  - Outputs: `pc_en=0`, `flush[0]=1`, downstream latches enabled.
  - Memstall rules still apply.
  - `drain_cnt` decrements only on non-stall cycles.
  - When it reaches 0, go to HALTED.
  - Redirects in DRAIN are ignored; the wrong path is already squashed.
- HALTED: `pc_en=0`, `en` all zeros, `flush` all zeros, `halted=1`. Only RST exits.
- `stall_count`:
  - Increments on every cycle with `pc_en=0` in RUN or DRAIN.
  - Saturates at all ones.
  - Frozen in HALTED.

## Timing
- All enable/flush/`pc_en` outputs are combinational from inputs and current state, with zero-cycle latency. They must settle before the latch edge.
- `halted`, `redir_pend`, `halt_pend`, `drain_cnt` and `stall_count` are registered and update on the `CLK` rising edge.
- Outputs while RST is high: `pc_en=0`, `en=0`, `flush` all ones, `halted=0`.
- State after the reset edge: RUN, `stall_count=0`, both pend flags 0, `drain_cnt=0`.
- RST mid-DRAIN or in HALTED returns to RUN on the next edge.
- Simultaneous redirect and `~ihit`: redirect wins, `pc_en=1`.
- Simultaneous redirect and loaduse: redirect wins, no stall (the dependent instruction is wrong-path).
- Simultaneous halt and redirect: redirect is applied and halt is dropped, since the halt instruction is wrong-path when `HALT_STAGE`<`BR_STAGE`.

## Structure
- `haz_state_t` (RUN/DRAIN/HALTED) goes in `cpu_types_pkg`.
- A `hazard_ctrl_if` interface carries the ports, with modport `haz`.
- Elaboration checks: `0<BR_STAGE<MEM_STAGE<NSTAGES` and `HALT_STAGE<NSTAGES`.
- No sub-module; the load-use comparator is inline.

## Test plan
All values use default parameters.
- **Reset:** hold RST for 2 cycles → `en=4'b0000`, `flush=4'b1111`, `pc_en=0`. After release → `en=4'b1111`, `flush=0`, `stall_count=0`.
- **Data stall:** `dmemREN=1`, `dhit=0` for 3 cycles, then `dhit=1` → during the stall `pc_en=0`, `en=4'b1000`, `flush=4'b1000`. Afterwards normal outputs and `stall_count=3`.
- **Redirect during stall:** `mispredict` pulses during a dmem stall → `redir_pend=1`. The first cycle after `dhit` gives `pc_en=1`, `flush=4'b0011`; the next cycle `flush=0`.
- **Load-use:** `ex_memread=1`, `ex_rd=5`, `id_rt=5` → `pc_en=0`, `en=4'b1110`, `flush=4'b0010`. Repeating with `ex_rd=0` → no stall.
- **Halt drain:** `halt=1` → 3 DRAIN cycles with `flush[0]=1`, then `halted=1` and `en=0` held until RST. A dmem stall injected in DRAIN extends it by the number of stall cycles.
- **Fetch miss vs redirect:** `ihit=0` together with `jumping=1` → `pc_en=1`, `flush=4'b0011`. `ihit=0` alone → `pc_en=0`, `flush=4'b0001`.
